mem_wide_narrow_sched: RTL and testbench

// - Starvation-avoidance scheduler in front of mem_wide_narrow_mux; gates the valids of the wide (DMA) and ext ports.
// - The mux's static priority (wide > ext > narrow) is kept, but bounded by counters:
//   - wide/ext bursts are cut into fixed narrow windows;
//   - ext is boosted over wide after a bounded wait.
// - The mux still sees immediate grants; this block only decides which wide-class valid reaches it.

---
 rtl/mem_sched_pkg.sv | 18 +
 rtl/mem_sched_sat_ctr.sv | 28 ++
 rtl/mem_wide_narrow_sched.sv | 146 ++++++++++++++
 tb/tb_mem_wide_narrow_sched.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_sched_pkg.sv
// Shared types for the wide/narrow starvation-avoidance scheduler.
// Owner encoding is visible on the top-level owner_o port.
package mem_sched_pkg;

  localparam int DefCntWidth = 8;

  typedef enum logic [1:0] {
    OwnNarrow = 2'd0,
    OwnWide   = 2'd1,
    OwnExt    = 2'd2
  } owner_e;

  typedef enum logic {
    Open      = 1'b0,
    NarrowWin = 1'b1
  } sched_state_e;

endpackage

// File: rtl/mem_sched_sat_ctr.sv
// Saturating up-counter with clear, load and enable; clr > load > en.
// Latency: value updates on the next clk_i edge. No backpressure.
// Holds at all-ones rather than wrapping.
module mem_sched_sat_ctr #(
  parameter int Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic [Width-1:0] cnt_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= '0;
    end else if (load_i) begin
      cnt_o <= load_val_i;
    end else if (en_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + 1'b1;
    end
  end

endmodule

// File: rtl/mem_wide_narrow_sched.sv
// Gates wide/ext valids ahead of the wide/narrow mux so narrow ports get windows and ext gets boosted.
// Latency: 0 (valid gating is combinational from registered state). Backpressure: ready passes through, masked by gated valid.
// Optional stats ports when MEM_WIDE_NARROW_SCHED_STATS_EN is defined.
module mem_wide_narrow_sched
  import mem_sched_pkg::*;
#(
  parameter int NrPorts      = 4,
  parameter int MaxWideRun   = 16,
  parameter int NarrowWindow = 4,
  parameter int MaxExtWait   = 8,
  parameter int CntWidth     = DefCntWidth
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               wide_valid_i,
  output logic               wide_ready_o,
  output logic               wide_valid_o,
  input  logic               wide_ready_i,
  input  logic               ext_valid_i,
  output logic               ext_ready_o,
  output logic               ext_valid_o,
  input  logic               ext_ready_i,
  input  logic [NrPorts-1:0] narrow_valid_i,
  output owner_e             owner_o
`ifdef MEM_WIDE_NARROW_SCHED_STATS_EN
  ,
  output logic [31:0]        stat_throttle_o,
  output logic [31:0]        stat_boost_o
`endif
);

  localparam logic [CntWidth-1:0] RunLast  = CntWidth'(MaxWideRun - 1);
  localparam logic [CntWidth-1:0] WinLast  = CntWidth'(NarrowWindow - 1);
  localparam logic [CntWidth-1:0] WaitLast = CntWidth'(MaxExtWait - 1);
  localparam logic [CntWidth-1:0] WinLen   = CntWidth'(NarrowWindow);

  sched_state_e        state;
  logic                boost;
  logic [CntWidth-1:0] run_cnt, win_cnt, wait_cnt;
  logic                in_win, mask_wide, mask_ext, narrow_pend;
  logic                wide_beat, ext_beat, beat, wait_inc;
  logic                enter_win, exit_win, boost_set;

  assign in_win       = (state == NarrowWin);
  assign mask_wide    = in_win | (boost & ext_valid_i);
  assign mask_ext     = in_win;
  assign wide_valid_o = wide_valid_i & ~mask_wide;
  assign ext_valid_o  = ext_valid_i & ~mask_ext;
  assign wide_ready_o = wide_ready_i & wide_valid_o;
  assign ext_ready_o  = ext_ready_i & ext_valid_o;

  assign narrow_pend = |narrow_valid_i;
  assign wide_beat   = wide_valid_o & wide_ready_i;
  assign ext_beat    = ext_valid_o & ext_ready_i;
  assign beat        = wide_beat | ext_beat;
  // Both valids are masked in the window, so wait_inc and ext_beat are 0 there: boost/wait freeze.
  assign wait_inc    = ext_valid_i & wide_valid_o;

  assign enter_win = (MaxWideRun != 0) && !in_win && beat && narrow_pend && (run_cnt == RunLast);
  assign exit_win  = in_win && (!narrow_pend || (win_cnt == WinLast));
  assign boost_set = (MaxExtWait != 0) && !in_win && wait_inc && (wait_cnt == WaitLast);

  always_comb begin
    owner_o = OwnNarrow;
    if (wide_beat)     owner_o = OwnWide;
    else if (ext_beat) owner_o = OwnExt;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= Open;
      boost <= 1'b0;
    end else begin
      case (state)
        Open:      if (enter_win) state <= NarrowWin;
        NarrowWin: if (exit_win)  state <= Open;
        default:   state <= Open;
      endcase
      if (ext_beat)       boost <= 1'b0;
      else if (boost_set) boost <= 1'b1;
    end
  end

  // run_cnt has no beats inside the window, so it reads 0 on every exit.
  mem_sched_sat_ctr #(.Width(CntWidth)) u_run_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (!(beat && narrow_pend)),
    .en_i       (beat && narrow_pend),
    .load_i     (1'b0),
    .load_val_i ('0),
    .cnt_o      (run_cnt)
  );

  mem_sched_sat_ctr #(.Width(CntWidth)) u_win_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (!in_win),
    .en_i       (in_win),
    .load_i     (1'b0),
    .load_val_i ('0),
    .cnt_o      (win_cnt)
  );

  mem_sched_sat_ctr #(.Width(CntWidth)) u_wait_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (!in_win && (ext_beat || !ext_valid_i)),
    .en_i       (wait_inc),
    .load_i     (1'b0),
    .load_val_i ('0),
    .cnt_o      (wait_cnt)
  );

`ifdef MEM_WIDE_NARROW_SCHED_STATS_EN
  mem_sched_sat_ctr #(.Width(32)) u_stat_throttle (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (1'b0),
    .en_i       (enter_win),
    .load_i     (1'b0),
    .load_val_i ('0),
    .cnt_o      (stat_throttle_o)
  );

  mem_sched_sat_ctr #(.Width(32)) u_stat_boost (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (1'b0),
    .en_i       (boost && ext_beat),
    .load_i     (1'b0),
    .load_val_i ('0),
    .cnt_o      (stat_boost_o)
  );
`endif

`ifndef SYNTHESIS
  a_wide_grant: assert property (@(posedge clk_i) disable iff (rst_i)
    wide_valid_o |-> wide_ready_i);
  a_no_wide_in_win: assert property (@(posedge clk_i) disable iff (rst_i)
    !(wide_valid_o && in_win));
  a_win_len: assert property (@(posedge clk_i) disable iff (rst_i)
    in_win |-> (win_cnt < WinLen));
`endif

endmodule

// File: tb/tb_mem_wide_narrow_sched.sv
// Directed bench for mem_wide_narrow_sched with a cycle-level reference model and literal scenario checks.
module tb_mem_wide_narrow_sched;
  import mem_sched_pkg::*;

  localparam int NrPorts      = 4;
  localparam int MaxWideRun   = 16;
  localparam int NarrowWindow = 4;
  localparam int MaxExtWait   = 8;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic               rst_i, wide_valid_i, wide_ready_i, ext_valid_i, ext_ready_i;
  logic [NrPorts-1:0] narrow_valid_i;
  logic               wide_ready_o, wide_valid_o, ext_ready_o, ext_valid_o;
  owner_e             owner_o;
`ifdef MEM_WIDE_NARROW_SCHED_STATS_EN
  logic [31:0]        stat_throttle_o, stat_boost_o;
`endif

  // Mux stand-in: static priority wide > ext, immediate grant.
  assign wide_ready_i = 1'b1;
  assign ext_ready_i  = ext_valid_o & ~wide_valid_o;

  mem_wide_narrow_sched #(
    .NrPorts(NrPorts), .MaxWideRun(MaxWideRun), .NarrowWindow(NarrowWindow),
    .MaxExtWait(MaxExtWait), .CntWidth(8)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .wide_valid_i   (wide_valid_i),
    .wide_ready_o   (wide_ready_o),
    .wide_valid_o   (wide_valid_o),
    .wide_ready_i   (wide_ready_i),
    .ext_valid_i    (ext_valid_i),
    .ext_ready_o    (ext_ready_o),
    .ext_valid_o    (ext_valid_o),
    .ext_ready_i    (ext_ready_i),
    .narrow_valid_i (narrow_valid_i),
    .owner_o        (owner_o)
`ifdef MEM_WIDE_NARROW_SCHED_STATS_EN
    ,
    .stat_throttle_o(stat_throttle_o),
    .stat_boost_o   (stat_boost_o)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, got, exp);
    end
  endtask

  // Reference model: window as a countdown of remaining masked cycles,
  // run as the number of consecutive granted beats with narrow waiting.
  bit chk_en = 1'b0;
  int m_run = 0, m_win_left = 0, m_wait = 0;
  bit m_boost = 1'b0;
  int m_throttles = 0, m_boosts = 0;

  always @(negedge clk_i) begin
    bit np, in_win, e_wvo, e_evo, wb, eb;
    int e_own;
    if (chk_en) begin
      np     = |narrow_valid_i;
      in_win = (m_win_left > 0);
      e_wvo  = wide_valid_i && !in_win && !(m_boost && ext_valid_i);
      e_evo  = ext_valid_i && !in_win;
      wb     = e_wvo;
      eb     = e_evo && !e_wvo;
      e_own  = wb ? int'(OwnWide) : (eb ? int'(OwnExt) : int'(OwnNarrow));
      check("cmp_wide_valid", int'(wide_valid_o), int'(e_wvo));
      check("cmp_ext_valid",  int'(ext_valid_o),  int'(e_evo));
      check("cmp_wide_ready", int'(wide_ready_o), int'(wb));
      check("cmp_ext_ready",  int'(ext_ready_o),  int'(eb));
      check("cmp_owner",      int'(owner_o),      e_own);
`ifdef MEM_WIDE_NARROW_SCHED_STATS_EN
      check("cmp_stat_throttle", int'(stat_throttle_o), m_throttles);
      check("cmp_stat_boost",    int'(stat_boost_o),    m_boosts);
`endif
      if (rst_i) begin
        m_run = 0; m_win_left = 0; m_wait = 0; m_boost = 1'b0;
        m_throttles = 0; m_boosts = 0;
      end else if (in_win) begin
        m_run = 0;
        if (!np || m_win_left == 1) m_win_left = 0;
        else                        m_win_left--;
      end else begin
        if ((wb || eb) && np) begin
          m_run++;
          if (MaxWideRun != 0 && m_run == MaxWideRun) begin
            m_win_left = NarrowWindow;
            m_run      = 0;
            m_throttles++;
          end
        end else begin
          m_run = 0;
        end
        if (eb) begin
          if (m_boost) m_boosts++;
          m_wait  = 0;
          m_boost = 1'b0;
        end else if (!ext_valid_i) begin
          m_wait = 0;
        end else if (e_wvo) begin
          m_wait++;
          if (MaxExtWait != 0 && m_wait == MaxExtWait) m_boost = 1'b1;
        end
      end
    end
  end

  // One cycle of stimulus; inputs change just after posedge, outputs captured at negedge.
  task automatic cyc(input bit r, input bit wv, input bit ev, input bit np,
                     output bit owvo, output int oown);
    rst_i          = r;
    wide_valid_i   = wv;
    ext_valid_i    = ev;
    narrow_valid_i = np ? 4'b0001 : 4'b0000;
    @(negedge clk_i);
    owvo = wide_valid_o;
    oown = int'(owner_o);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    bit w;
    int o, n;
    rst_i = 1'b1; wide_valid_i = 1'b0; ext_valid_i = 1'b0; narrow_valid_i = '0;
    @(posedge clk_i); #1;
    chk_en = 1'b1;

    // Reset state: outputs follow the Open equations, not forced low.
    cyc(1, 1, 0, 0, w, o);
    check("reset_wide_passes", int'(w), 1);
    check("reset_owner_wide", o, int'(OwnWide));
    cyc(0, 0, 0, 0, w, o);
    check("idle_owner_narrow", o, int'(OwnNarrow));

    // Throttle: 16 wide beats then 4 masked cycles, three times.
    n = 0;
    for (int i = 0; i < 60; i++) begin
      cyc(0, 1, 0, 1, w, o);
      check($sformatf("throttle_wide_c%0d", i), int'(w), ((i % 20) < 16) ? 1 : 0);
      if ((i % 20) >= 16) check($sformatf("throttle_owner_c%0d", i), o, int'(OwnNarrow));
      n += int'(w);
    end
    check("throttle_beats", n, 48);
`ifdef MEM_WIDE_NARROW_SCHED_STATS_EN
    check("stat_throttle_3", int'(stat_throttle_o), 3);
    check("stat_boost_0", int'(stat_boost_o), 0);
`endif

    // Early exit: narrow drops in the second window cycle.
    cyc(0, 0, 0, 0, w, o);
    for (int i = 0; i < 16; i++) cyc(0, 1, 0, 1, w, o);
    cyc(0, 1, 0, 1, w, o);
    check("early_win_c1_masked", int'(w), 0);
    cyc(0, 1, 0, 0, w, o);
    check("early_win_c2_masked", int'(w), 0);
    for (int i = 0; i < 17; i++) begin
      cyc(0, 1, 0, 1, w, o);
      check($sformatf("early_after_c%0d", i), int'(w), (i < 16) ? 1 : 0);
    end
    cyc(0, 0, 0, 0, w, o);
    cyc(0, 0, 0, 0, w, o);

    // No narrow: never throttled.
    n = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(0, 1, 0, 0, w, o);
      n += int'(w);
    end
    check("no_narrow_beats", n, 100);

    // Ext boost: 8 wide beats, one boosted ext beat, repeat.
    for (int i = 0; i < 18; i++) begin
      cyc(0, 1, 1, 0, w, o);
      check($sformatf("boost_owner_c%0d", i), o,
            (i == 8 || i == 17) ? int'(OwnExt) : int'(OwnWide));
    end
    cyc(0, 0, 0, 0, w, o);
`ifdef MEM_WIDE_NARROW_SCHED_STATS_EN
    check("stat_boost_2", int'(stat_boost_o), 2);
`endif

    // Reset in window cycle 1: Open again on the next cycle.
    for (int i = 0; i < 16; i++) cyc(0, 1, 0, 1, w, o);
    cyc(1, 1, 0, 1, w, o);
    check("rst_win_c1_masked", int'(w), 0);
    cyc(0, 1, 0, 1, w, o);
    check("rst_then_open", int'(w), 1);
    check("rst_then_owner", o, int'(OwnWide));
`ifdef MEM_WIDE_NARROW_SCHED_STATS_EN
    check("stat_throttle_after_rst", int'(stat_throttle_o), 0);
`endif
    cyc(0, 0, 0, 0, w, o);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
